cdb_arbiter: RTL

Arbiter that shares the single common data bus (CDB) among the three result producers: the reservation-station ALU, the branch unit and the store/load buffer. Each producer pushes (ROB entry, value) results into a small per-source queue. Every cycle the arbiter grants at most one queued result and broadcasts it on a registered CDB. The ROB, the reservation station and the store/load buffer all consume that broadcast.

---
 rtl/cdb_arbiter_pkg.sv | 16 +
 rtl/cdb_src_fifo.sv | 57 +++++
 rtl/cdb_arbiter.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/cdb_arbiter_pkg.sv
// Shared CDB definitions: source ids, default ROB tag width, broadcast packet.
// Used by the arbiter, the ROB and the reservation station.
package cdb_arbiter_pkg;

    localparam int DEF_ENTRY_W = 4;

    localparam logic [1:0] SRC_ALU = 2'd0;
    localparam logic [1:0] SRC_BR  = 2'd1;
    localparam logic [1:0] SRC_SLB = 2'd2;

    typedef struct packed {
        logic [DEF_ENTRY_W-1:0] entry;
        logic [31:0]            value;
    } cdb_pkt_t;

endpackage

// File: rtl/cdb_src_fifo.sv
// Per-source result queue feeding the CDB arbiter.
// Flush clears pointers and count; ready comes from the registered count only.
module cdb_src_fifo #(
    parameter int W     = 36,
    parameter int DEPTH = 2
) (
    input  logic                       clk_in,
    input  logic                       rst_in,
    input  logic                       rdy_in,
    input  logic                       flush_in,
    input  logic                       push,
    input  logic [W-1:0]               din,
    input  logic                       pop,
    output logic [W-1:0]               head,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       ready
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          push_ok;
    logic          pop_ok;

    assign ready   = rdy_in && (count < CW'(DEPTH));
    assign push_ok = push && ready && !flush_in;
    assign pop_ok  = pop && rdy_in && !flush_in;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk_in) begin
        if (push_ok)
            mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (rdy_in) begin
            if (flush_in) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (push_ok)
                    wr_ptr <= wr_ptr + AW'(1);
                if (pop_ok)
                    rd_ptr <= rd_ptr + AW'(1);
                count <= count + CW'(push_ok) - CW'(pop_ok);
            end
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: three queued producers, one registered broadcast.
// Define CDB_RR_EN for round-robin; otherwise fixed priority branch > SLB > ALU.
module cdb_arbiter
    import cdb_arbiter_pkg::*;
#(
    parameter int ENTRY_W = DEF_ENTRY_W,
    parameter int DEPTH   = 2
) (
    input  logic               clk_in,
    input  logic               rst_in,
    input  logic               rdy_in,
    input  logic               flush_in,
    input  logic               alu_valid,
    input  logic [ENTRY_W-1:0] alu_entry,
    input  logic [31:0]        alu_value,
    input  logic               br_valid,
    input  logic [ENTRY_W-1:0] br_entry,
    input  logic [31:0]        br_value,
    input  logic               slb_valid,
    input  logic [ENTRY_W-1:0] slb_entry,
    input  logic [31:0]        slb_value,
    output logic               alu_ready,
    output logic               br_ready,
    output logic               slb_ready,
    output logic               have_cdb,
    output logic [ENTRY_W-1:0] entry_cdb,
    output logic [31:0]        value_cdb,
    output logic [1:0]         src_cdb
);
    localparam int PW = ENTRY_W + 32;
    localparam int CW = $clog2(DEPTH) + 1;

    logic [2:0]    valid;
    logic [2:0]    ready;
    logic [2:0]    nonempty;
    logic [2:0]    pop;
    logic [PW-1:0] din   [3];
    logic [PW-1:0] head  [3];
    logic [CW-1:0] count [3];
    logic [PW-1:0] gnt_pkt;
    logic          gnt_vld;
    logic [1:0]    gnt;

    assign valid  = {slb_valid, br_valid, alu_valid};
    assign din[0] = {alu_entry, alu_value};
    assign din[1] = {br_entry, br_value};
    assign din[2] = {slb_entry, slb_value};
    assign {slb_ready, br_ready, alu_ready} = ready;

    for (genvar i = 0; i < 3; i++) begin : g_q
        cdb_src_fifo #(.W(PW), .DEPTH(DEPTH)) u_q (
            .clk_in   (clk_in),
            .rst_in   (rst_in),
            .rdy_in   (rdy_in),
            .flush_in (flush_in),
            .push     (valid[i]),
            .din      (din[i]),
            .pop      (pop[i]),
            .head     (head[i]),
            .count    (count[i]),
            .ready    (ready[i])
        );
        assign nonempty[i] = (count[i] != '0);
        assign pop[i] = gnt_vld && (gnt == 2'(i));
    end

`ifdef CDB_RR_EN
    logic [1:0] last_src;
    logic [1:0] start;
    logic [2:0] sum;
    logic [1:0] cand;

    always_comb begin
        gnt_vld = 1'b0;
        gnt     = SRC_ALU;
        sum     = '0;
        cand    = '0;
        start   = (last_src == SRC_SLB) ? SRC_ALU : last_src + 2'd1;
        for (int k = 0; k < 3; k++) begin
            sum  = {1'b0, start} + 3'(k);
            cand = (sum >= 3'd3) ? 2'(sum - 3'd3) : sum[1:0];
            if (!gnt_vld && nonempty[cand]) begin
                gnt_vld = 1'b1;
                gnt     = cand;
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in)
            last_src <= SRC_ALU;
        else if (rdy_in) begin
            if (flush_in)
                last_src <= SRC_ALU;
            else if (gnt_vld)
                last_src <= gnt;
        end
    end
`else
    always_comb begin
        gnt_vld = 1'b1;
        gnt     = SRC_ALU;
        if (nonempty[SRC_BR])
            gnt = SRC_BR;
        else if (nonempty[SRC_SLB])
            gnt = SRC_SLB;
        else if (nonempty[SRC_ALU])
            gnt = SRC_ALU;
        else
            gnt_vld = 1'b0;
    end
`endif

    always_comb begin
        gnt_pkt = head[0];
        if (gnt == SRC_BR)
            gnt_pkt = head[1];
        else if (gnt == SRC_SLB)
            gnt_pkt = head[2];
    end

    // Tag/value/source hold their last broadcast while the bus is idle.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            have_cdb  <= 1'b0;
            entry_cdb <= '0;
            value_cdb <= '0;
            src_cdb   <= SRC_ALU;
        end else if (rdy_in) begin
            if (flush_in)
                have_cdb <= 1'b0;
            else if (gnt_vld) begin
                have_cdb  <= 1'b1;
                entry_cdb <= gnt_pkt[PW-1:32];
                value_cdb <= gnt_pkt[31:0];
                src_cdb   <= gnt;
            end else
                have_cdb <= 1'b0;
        end
    end

endmodule
